win3x3_gen: RTL and testbench



---
 rtl/win3x3_pkg.sv | 27 ++
 rtl/win3x3_linebuf.sv | 24 ++
 rtl/win3x3_gen.sv | 150 +++++++++++++++
 tb/tb_win3x3_gen.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/win3x3_pkg.sv
// Shared constants for the 3x3 window generator: default sizes, counter widths and tap order.
package win3x3_pkg;

  localparam int DW_DEF         = 8;
  localparam int IMG_WIDTH_DEF  = 640;
  localparam int IMG_HEIGHT_DEF = 480;

  localparam int COL_W = $clog2(IMG_WIDTH_DEF);
  localparam int ROW_W = $clog2(IMG_HEIGHT_DEF);

  // Tap order: row-major, row 0 = oldest line, column 0 = oldest column
  localparam int TAP_A00  = 0;
  localparam int TAP_A01  = 1;
  localparam int TAP_A02  = 2;
  localparam int TAP_A10  = 3;
  localparam int TAP_A11  = 4;
  localparam int TAP_A12  = 5;
  localparam int TAP_A20  = 6;
  localparam int TAP_A21  = 7;
  localparam int TAP_A22  = 8;
  localparam int NUM_TAPS = 9;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/win3x3_linebuf.sv
// One line of pixel storage: asynchronous read, synchronous write on we, same address for both.
module win3x3_linebuf
  import win3x3_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = IMG_WIDTH_DEF,
  parameter int AW    = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/win3x3_gen.sv
// Raster pixel stream to sliding 3x3 window with valid and first-window flags.
// Define WIN3X3_OUTREG_EN to add an output register stage (2 clk latency).
module win3x3_gen
  import win3x3_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
  parameter int IMG_HEIGHT = IMG_HEIGHT_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pixelEN,
  input  logic [DW-1:0] pix_in,
  input  logic          sof_in,
  output logic [DW-1:0] A00,
  output logic [DW-1:0] A01,
  output logic [DW-1:0] A02,
  output logic [DW-1:0] A10,
  output logic [DW-1:0] A11,
  output logic [DW-1:0] A12,
  output logic [DW-1:0] A20,
  output logic [DW-1:0] A21,
  output logic [DW-1:0] A22,
  output logic          win_valid,
  output logic          win_sof
);

  localparam int CW = cnt_width(IMG_WIDTH);
  localparam int RW = cnt_width(IMG_HEIGHT);

  logic          accept;
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic [DW-1:0] win_q [NUM_TAPS];
  logic [DW-1:0] win_d [NUM_TAPS];
  logic          valid_q, valid_d;
  logic          sof_q, sof_d;
  logic [DW-1:0] lb0_rd, lb1_rd;
  logic [DW-1:0] out_taps [NUM_TAPS];
  logic          out_valid, out_sof;

  assign accept = en && pixelEN && !rst;

  // lb0 holds the previous line, lb1 the one before; lb1 takes lb0's old value
  win3x3_linebuf #(.DW(DW), .DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
    .clk(clk), .we(accept), .addr(cur_col), .wdata(pix_in), .rdata(lb0_rd)
  );

  win3x3_linebuf #(.DW(DW), .DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
    .clk(clk), .we(accept), .addr(cur_col), .wdata(lb0_rd), .rdata(lb1_rd)
  );

  always_comb begin
    cur_col = sof_in ? '0 : col_q;
    cur_row = sof_in ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    if (accept) begin
      if (cur_col == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
      win_d[TAP_A00] = win_q[TAP_A01];
      win_d[TAP_A01] = win_q[TAP_A02];
      win_d[TAP_A02] = lb1_rd;
      win_d[TAP_A10] = win_q[TAP_A11];
      win_d[TAP_A11] = win_q[TAP_A12];
      win_d[TAP_A12] = lb0_rd;
      win_d[TAP_A20] = win_q[TAP_A21];
      win_d[TAP_A21] = win_q[TAP_A22];
      win_d[TAP_A22] = pix_in;
      valid_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      sof_d   = (cur_row == RW'(2)) && (cur_col == CW'(2));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) win_q[i] <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      win_q   <= win_d;
    end
  end

`ifdef WIN3X3_OUTREG_EN
  logic [DW-1:0] out_q [NUM_TAPS];
  logic [DW-1:0] out_d [NUM_TAPS];
  logic          out_valid_q, out_valid_d;
  logic          out_sof_q, out_sof_d;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    if (en) begin
      out_d       = win_q;
      out_valid_d = valid_q;
      out_sof_d   = sof_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) out_q[i] <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_q       <= out_d;
    end
  end

  assign out_taps  = out_q;
  assign out_valid = out_valid_q;
  assign out_sof   = out_sof_q;
`else
  assign out_taps  = win_q;
  assign out_valid = valid_q;
  assign out_sof   = sof_q;
`endif

  assign A00       = out_taps[TAP_A00];
  assign A01       = out_taps[TAP_A01];
  assign A02       = out_taps[TAP_A02];
  assign A10       = out_taps[TAP_A10];
  assign A11       = out_taps[TAP_A11];
  assign A12       = out_taps[TAP_A12];
  assign A20       = out_taps[TAP_A20];
  assign A21       = out_taps[TAP_A21];
  assign A22       = out_taps[TAP_A22];
  assign win_valid = out_valid;
  assign win_sof   = out_sof;

endmodule

// File: tb/tb_win3x3_gen.sv
// Directed bench for win3x3_gen on an 8x6 frame; pixel value = row*16 + col (plus a base offset).
module tb_win3x3_gen;

  localparam int W = 8;
  localparam int H = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pixel_en;
  logic       sof_in;
  logic [7:0] pix_in;
  logic [7:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
  logic       win_valid;
  logic       win_sof;

  int total = 0;
  int bad   = 0;

  logic [71:0] win_vec;
  assign win_vec = {a00, a01, a02, a10, a11, a12, a20, a21, a22};

  always #5 clk = ~clk;

  win3x3_gen #(.DW(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst), .en(en), .pixelEN(pixel_en), .pix_in(pix_in), .sof_in(sof_in),
    .A00(a00), .A01(a01), .A02(a02), .A10(a10), .A11(a11), .A12(a12),
    .A20(a20), .A21(a21), .A22(a22), .win_valid(win_valid), .win_sof(win_sof)
  );

  // One accept followed by two idle cycles; outputs are settled for either latency afterwards
  task automatic send(input logic [7:0] p, input logic s);
    @(negedge clk);
    pix_in   = p;
    sof_in   = s;
    pixel_en = 1'b1;
    @(negedge clk);
    pixel_en = 1'b0;
    sof_in   = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic stream(input int r0, input int c0, input int r1, input int c1, input logic [7:0] base);
    int r = r0;
    int c = c0;
    forever begin
      send(base + 8'(r * 16 + c), 1'b0);
      if (r == r1 && c == c1) break;
      if (c == W - 1) begin
        c = 0;
        r = (r == H - 1) ? 0 : r + 1;
      end else begin
        c = c + 1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; pixel_en = 1'b0; sof_in = 1'b0; pix_in = 8'h00;
    repeat (3) @(negedge clk);
    total++;
    if ({win_vec, win_valid, win_sof} !== 74'h0) begin
      bad++;
      $display("[TB] FAIL reset_state: got %h/%b/%b want all zero", win_vec, win_valid, win_sof);
    end
    rst = 1'b0;
  endtask

  task automatic test_first_window();
    send(8'h00, 1'b1);
    stream(0, 1, 2, 1, 8'h00);
    total++;
    if (win_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL valid_2_1: got %b want 0", win_valid);
    end
    send(8'h22, 1'b0);
    total++;
    if ({win_valid, win_sof} !== 2'b11) begin
      bad++;
      $display("[TB] FAIL flags_2_2: got valid=%b sof=%b want 1 1", win_valid, win_sof);
    end
    total++;
    if (win_vec !== 72'h00_01_02_10_11_12_20_21_22) begin
      bad++;
      $display("[TB] FAIL window_2_2: got %h want 000102101112202122", win_vec);
    end
    stream(2, 3, 3, 1, 8'h00);
    total++;
    if (win_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL valid_3_1: got %b want 0", win_valid);
    end
    send(8'h32, 1'b0);
    total++;
    if ({win_valid, win_sof, a00, a11, a22} !== {2'b10, 8'h10, 8'h21, 8'h32}) begin
      bad++;
      $display("[TB] FAIL window_3_2: got v=%b s=%b a00=%h a11=%h a22=%h want 1 0 10 21 32",
               win_valid, win_sof, a00, a11, a22);
    end
  endtask

  task automatic test_hold();
    logic [73:0] exp_hold;
    exp_hold = {72'h23_24_25_33_34_35_43_44_45, 2'b10};
    stream(3, 3, 4, 5, 8'h00);
    total++;
    if ({win_vec, win_valid, win_sof} !== exp_hold) begin
      bad++;
      $display("[TB] FAIL window_4_5: got %h/%b/%b want %h", win_vec, win_valid, win_sof, exp_hold);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({win_vec, win_valid, win_sof} !== exp_hold) begin
        bad++;
        $display("[TB] FAIL hold_pixen_low[%0d]: got %h/%b/%b want %h", i, win_vec, win_valid, win_sof, exp_hold);
      end
    end
    en = 1'b0; pixel_en = 1'b1; sof_in = 1'b1; pix_in = 8'hFF;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({win_vec, win_valid, win_sof} !== exp_hold) begin
        bad++;
        $display("[TB] FAIL hold_en_low[%0d]: got %h/%b/%b want %h", i, win_vec, win_valid, win_sof, exp_hold);
      end
    end
    en = 1'b1; pixel_en = 1'b0; sof_in = 1'b0;
    send(8'h46, 1'b0);
    total++;
    if ({win_valid, a11, a22} !== {1'b1, 8'h35, 8'h46}) begin
      bad++;
      $display("[TB] FAIL after_hold_4_6: got v=%b a11=%h a22=%h want 1 35 46", win_valid, a11, a22);
    end
  endtask

  task automatic test_wrap();
    stream(4, 7, 5, 7, 8'h00);
    total++;
    if ({win_valid, win_sof, a11, a22} !== {2'b10, 8'h46, 8'h57}) begin
      bad++;
      $display("[TB] FAIL last_pixel_5_7: got v=%b s=%b a11=%h a22=%h want 1 0 46 57", win_valid, win_sof, a11, a22);
    end
    send(8'h00, 1'b0);
    total++;
    if ({win_valid, a12, a22} !== {1'b0, 8'h50, 8'h00}) begin
      bad++;
      $display("[TB] FAIL wrap_0_0: got v=%b a12=%h a22=%h want 0 50 00", win_valid, a12, a22);
    end
    stream(0, 1, 2, 1, 8'h00);
    send(8'h22, 1'b0);
    total++;
    if ({win_vec, win_valid, win_sof} !== {72'h00_01_02_10_11_12_20_21_22, 2'b11}) begin
      bad++;
      $display("[TB] FAIL frame2_first_window: got %h/%b/%b want 000102101112202122/1/1", win_vec, win_valid, win_sof);
    end
  endtask

  task automatic test_resync();
    stream(2, 3, 3, 3, 8'h00);
    send(8'h80, 1'b1);
    total++;
    if (win_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL resync_sof: got valid=%b want 0", win_valid);
    end
    for (int r = 0; r < 2; r++) begin
      for (int c = (r == 0) ? 1 : 0; c < W; c++) begin
        send(8'h80 + 8'(r * 16 + c), 1'b0);
        total++;
        if (win_valid !== 1'b0) begin
          bad++;
          $display("[TB] FAIL resync_valid_%0d_%0d: got %b want 0", r, c, win_valid);
        end
      end
    end
    stream(2, 0, 2, 1, 8'h80);
    send(8'hA2, 1'b0);
    total++;
    if ({win_vec, win_valid, win_sof} !== {72'h80_81_82_90_91_92_A0_A1_A2, 2'b11}) begin
      bad++;
      $display("[TB] FAIL resync_first_window: got %h/%b/%b want 808182909192a0a1a2/1/1", win_vec, win_valid, win_sof);
    end
  endtask

  task automatic test_reset_mid();
    stream(2, 3, 3, 3, 8'h80);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({win_vec, win_valid, win_sof} !== 74'h0) begin
      bad++;
      $display("[TB] FAIL reset_mid: got %h/%b/%b want all zero", win_vec, win_valid, win_sof);
    end
    rst = 1'b0;
    stream(0, 0, 2, 1, 8'h40);
    total++;
    if (win_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL post_reset_18th: got valid=%b want 0", win_valid);
    end
    send(8'h62, 1'b0);
    total++;
    if ({win_vec, win_valid, win_sof} !== {72'h40_41_42_50_51_52_60_61_62, 2'b11}) begin
      bad++;
      $display("[TB] FAIL post_reset_19th: got %h/%b/%b want 404142505152606162/1/1", win_vec, win_valid, win_sof);
    end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_hold();
    test_wrap();
    test_resync();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
